// File: rtl/sync_ff_filt_pkg.sv
// Shared constants and helpers for the sync_ff_filt synchronizer family.
// Optional edge outputs are controlled by the SYNC_FF_FILT_EDGE_EN macro.
package sync_ff_pkg;

    localparam int unsigned SYNC_FF_MIN_STAGES = 2;

    // Qualification counter width. Returns 1 in bypass so that the parameter stays legal.
    function automatic int unsigned sync_ff_cnt_width(input int unsigned filt_cycles);
        int unsigned w;
        if (filt_cycles == 0) begin
            w = 1;
        end else begin
            w = $clog2(filt_cycles + 1);
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_ff_filt_ch.sv
// One channel of sync_ff_filt: synchronizer chain, debounce filter and edge detect.
// Edge detection (q_dly_q, o_rise, o_fall) is built only when SYNC_FF_FILT_EDGE_EN is defined.
module sync_ff_filt_ch
    import sync_ff_pkg::*;
#(
    parameter int unsigned STAGES      = SYNC_FF_MIN_STAGES,
    parameter int unsigned FILT_CYCLES = 4,
    parameter int unsigned CNT_W       = sync_ff_cnt_width(FILT_CYCLES),
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    generate
        if (CNT_W < sync_ff_cnt_width(FILT_CYCLES)) begin : g_cnt_w_err
            $error("sync_ff_filt_ch: CNT_W too narrow for FILT_CYCLES");
        end
    endgenerate

    logic [STAGES-1:0] sync_q;
    logic              sync_s;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_d};
        end
    end

    assign sync_s = sync_q[STAGES-1];

    generate
        if (FILT_CYCLES == 0) begin : g_bypass
            assign o_q = sync_s;
        end else begin : g_filt
            localparam logic [CNT_W-1:0] CntMax = CNT_W'(FILT_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             lvl_q;
            logic             lvl_d;

            // Any cycle of agreement drops the count back to zero.
            always_comb begin
                cnt_d = '0;
                lvl_d = lvl_q;
                if (sync_s != lvl_q) begin
                    if (cnt_q == CntMax) begin
                        lvl_d = sync_s;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    cnt_q <= '0;
                    lvl_q <= RST_VAL;
                end else begin
                    cnt_q <= cnt_d;
                    lvl_q <= lvl_d;
                end
            end

            assign o_q = lvl_q;

            a_cnt_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
                cnt_q <= CntMax);
        end
    endgenerate

`ifdef SYNC_FF_FILT_EDGE_EN
    // o_q delayed by one cycle; shares RST_VAL with o_q so reset never makes a pulse.
    logic q_dly_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q_dly_q <= RST_VAL;
        end else begin
            q_dly_q <= o_q;
        end
    end

    assign o_rise = o_q & ~q_dly_q;
    assign o_fall = ~o_q & q_dly_q;

    a_edge_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(o_rise && o_fall));
`else
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/sync_ff_filt.sv
// Multi-bit level synchronizer with per-channel debounce filter and reset value.
// Define SYNC_FF_FILT_EDGE_EN to build the o_rise/o_fall edge pulses; otherwise they read 0.
module sync_ff_filt
    import sync_ff_pkg::*;
#(
    parameter int unsigned      WIDTH       = 1,
    parameter int unsigned      STAGES      = 2,
    parameter int unsigned      FILT_CYCLES = 4,
    parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b0}}
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    localparam int unsigned CNT_W = sync_ff_cnt_width(FILT_CYCLES);

    generate
        if (STAGES < SYNC_FF_MIN_STAGES) begin : g_stages_err
            $error("sync_ff_filt: STAGES must be at least 2");
        end
        if (WIDTH == 0) begin : g_width_err
            $error("sync_ff_filt: WIDTH must be at least 1");
        end
    endgenerate

    // Channels are fully independent; no cross-bit coherency is provided.
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sync_ff_filt_ch #(
            .STAGES      (STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .CNT_W       (CNT_W),
            .RST_VAL     (RST_VAL[i])
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_d     (i_d[i]),
            .o_q     (o_q[i]),
            .o_rise  (o_rise[i]),
            .o_fall  (o_fall[i])
        );
    end

endmodule

// File: tb/tb_sync_ff_filt.sv
// Bench for sync_ff_filt: default, bypass (STAGES=3) and RST_VAL=4'b1010 instances
// checked every cycle against a sample-history model plus directed literal checks.
module tb_sync_ff_filt;

`ifdef SYNC_FF_FILT_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_ab;
    logic       rst_c;
    logic [3:0] d_a, d_c;
    logic [0:0] d_b;
    logic [3:0] q_a, rise_a, fall_a;
    logic [0:0] q_b, rise_b, fall_b;
    logic [3:0] q_c, rise_c, fall_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_ff_filt #(.WIDTH(4)) dut_a (
        .i_clk(clk), .i_rst_n(rst_ab), .i_d(d_a), .o_q(q_a), .o_rise(rise_a), .o_fall(fall_a)
    );
    sync_ff_filt #(.WIDTH(1), .STAGES(3), .FILT_CYCLES(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_ab), .i_d(d_b), .o_q(q_b), .o_rise(rise_b), .o_fall(fall_b)
    );
    sync_ff_filt #(.WIDTH(4), .RST_VAL(4'b1010)) dut_c (
        .i_clk(clk), .i_rst_n(rst_c), .i_d(d_c), .o_q(q_c), .o_rise(rise_c), .o_fall(fall_c)
    );

    // Model: inputs recorded per edge since reset release; outputs derived from the rules.
    bit [3:0] samp [3][4096];
    int       n    [3];
    bit [3:0] mq   [3];
    bit [3:0] mp   [3];

    function automatic int stg(int k);
        return (k == 1) ? 3 : 2;
    endfunction
    function automatic int filt(int k);
        return (k == 1) ? 0 : 4;
    endfunction
    function automatic int wid(int k);
        return (k == 1) ? 1 : 4;
    endfunction
    function automatic logic [3:0] rstv(int k);
        return (k == 2) ? 4'b1010 : 4'b0000;
    endfunction

    // Synchronized level after edge m: the input taken STAGES-1 edges earlier.
    function automatic bit s_post(int k, int ch, int m);
        int       idx;
        bit [3:0] v;
        idx = m - stg(k) + 1;
        if (idx < 1) v = rstv(k);
        else         v = samp[k][idx];
        return v[ch];
    endfunction

    task automatic model_reset(int k);
        n[k]  = 0;
        mq[k] = rstv(k);
        mp[k] = rstv(k);
    endtask

    task automatic model_step(int k, bit [3:0] d);
        bit [3:0] nq;
        bit       all_diff;
        n[k] = n[k] + 1;
        samp[k][n[k]] = d;
        mp[k] = mq[k];
        nq = mq[k];
        for (int ch = 0; ch < wid(k); ch++) begin
            if (filt(k) == 0) begin
                nq[ch] = s_post(k, ch, n[k]);
            end else begin
                // Flip once the last FILT_CYCLES synchronized levels all disagree with o_q.
                all_diff = 1'b1;
                for (int j = 0; j < filt(k); j++) begin
                    if (s_post(k, ch, n[k] - 1 - j) == mq[k][ch]) all_diff = 1'b0;
                end
                if (all_diff) nq[ch] = ~mq[k][ch];
            end
        end
        mq[k] = nq;
    endtask

    function automatic logic [3:0] e_rise(int k);
        return EDGE_EN ? (mq[k] & ~mp[k]) : 4'b0000;
    endfunction
    function automatic logic [3:0] e_fall(int k);
        return EDGE_EN ? (~mq[k] & mp[k]) : 4'b0000;
    endfunction

    always @(posedge clk or negedge rst_ab) begin
        if (!rst_ab) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, d_a);
            model_step(1, {3'b000, d_b});
        end
    end

    always @(posedge clk or negedge rst_c) begin
        if (!rst_c) model_reset(2);
        else        model_step(2, d_c);
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("a_q",    q_a,               mq[0]);
        chk("a_rise", rise_a,            e_rise(0));
        chk("a_fall", fall_a,            e_fall(0));
        chk("b_q",    {3'b000, q_b},     mq[1]);
        chk("b_rise", {3'b000, rise_b},  e_rise(1));
        chk("b_fall", {3'b000, fall_b},  e_fall(1));
        chk("c_q",    q_c,               mq[2]);
        chk("c_rise", rise_c,            e_rise(2));
        chk("c_fall", fall_c,            e_fall(2));
    end

    task automatic step(int cnt);
        repeat (cnt) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ab = 1'b0;
        rst_c  = 1'b0;
        d_a    = 4'b0000;
        d_b    = 1'b0;
        d_c    = 4'b1010;

        // Reset held with random input activity.
        repeat (10) begin
            @(negedge clk);
            d_a = 4'($urandom_range(15));
            d_b = 1'($urandom_range(1));
            d_c = 4'($urandom_range(15));
            #1;
            chk("rst_q_a", q_a, 4'b0000);
            chk("rst_q_c", q_c, 4'b1010);
            chk("rst_pulse_c", rise_c | fall_c, 4'b0000);
        end
        @(negedge clk);
        d_a = 4'b0000;
        d_b = 1'b0;
        d_c = 4'b1010;
        @(negedge clk);
        rst_ab = 1'b1;
        rst_c  = 1'b1;
        step(8);
        chk("rel_q_a", q_a, 4'b0000);
        chk("rel_q_c", q_c, 4'b1010);

        // Clean rising edge on channel 0: visible after edge 6.
        @(negedge clk);
        d_a[0] = 1'b1;
        step(5);
        chk("t2_q_e5", q_a, 4'b0000);
        step(1);
        chk("t2_q_e6", q_a, 4'b0001);
        chk("t2_rise_e6", rise_a, EDGE_EN ? 4'b0001 : 4'b0000);
        step(1);
        chk("t2_rise_e7", rise_a, 4'b0000);
        chk("t2_q_e7", q_a, 4'b0001);

        // Three-cycle glitch on channel 1 is swallowed.
        @(negedge clk);
        d_a[1] = 1'b1;
        repeat (3) @(negedge clk);
        d_a[1] = 1'b0;
        step(10);
        chk("t3_glitch_q", q_a, 4'b0001);

        // A four-cycle pulse then passes as a four-cycle level.
        @(negedge clk);
        d_a[1] = 1'b1;
        repeat (4) @(negedge clk);
        d_a[1] = 1'b0;
        step(2);
        chk("t3_pulse_q_e6", q_a, 4'b0011);
        chk("t3_pulse_rise", rise_a, EDGE_EN ? 4'b0010 : 4'b0000);
        step(3);
        chk("t3_pulse_q_e9", q_a, 4'b0011);
        step(1);
        chk("t3_pulse_q_e10", q_a, 4'b0001);
        chk("t3_pulse_fall", fall_a, EDGE_EN ? 4'b0010 : 4'b0000);

        // Interrupted qualification on channel 2.
        @(negedge clk);
        d_a[2] = 1'b1;
        repeat (3) @(negedge clk);
        d_a[2] = 1'b0;
        @(negedge clk);
        d_a[2] = 1'b1;
        step(5);
        chk("t4_q_e5", q_a, 4'b0001);
        step(1);
        chk("t4_q_e6", q_a, 4'b0101);

        // Bypass instance: three-edge latency, one-cycle pulse passes unchanged.
        @(negedge clk);
        d_b = 1'b1;
        step(2);
        chk("t5_q_e2", {3'b000, q_b}, 4'b0000);
        step(1);
        chk("t5_q_e3", {3'b000, q_b}, 4'b0001);
        @(negedge clk);
        d_b = 1'b0;
        step(3);
        chk("t5_fall_q", {3'b000, q_b}, 4'b0000);
        @(negedge clk);
        d_b = 1'b1;
        @(negedge clk);
        d_b = 1'b0;
        step(2);
        chk("t5_pulse_hi", {3'b000, q_b}, 4'b0001);
        step(1);
        chk("t5_pulse_lo", {3'b000, q_b}, 4'b0000);

        // RST_VAL instance: move off reset value, then reset while requalifying.
        @(negedge clk);
        d_c = 4'b0010;
        step(6);
        chk("t6_q_moved", q_c, 4'b0010);
        chk("t6_fall", fall_c, EDGE_EN ? 4'b1000 : 4'b0000);
        @(negedge clk);
        d_c = 4'b1010;
        step(3);
        #2;
        rst_c = 1'b0;
        #1;
        chk("t6_async_q", q_c, 4'b1010);
        chk("t6_async_rise", rise_c, 4'b0000);
        chk("t6_async_fall", fall_c, 4'b0000);
        repeat (3) @(negedge clk);
        rst_c = 1'b1;
        step(8);
        chk("t6_rel_q", q_c, 4'b1010);

        // Simultaneous falls on the default instance.
        @(negedge clk);
        d_a = 4'b0000;
        step(6);
        chk("tail_q_a", q_a, 4'b0000);
        chk("tail_fall_a", fall_a, EDGE_EN ? 4'b0101 : 4'b0000);
        step(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_ff_filt.md
# sync_ff_filt

Parametrised multi-bit synchronizer with configurable stage count, per-channel glitch/debounce filter, programmable reset value and optional edge-pulse outputs. Used wherever asynchronous level signals (straps, status pins, other-domain flags) enter an `i_clk` domain and must be clean, stable and edge-qualified before reaching control logic. With `STAGES=2`, `FILT_CYCLES=0` it is a drop-in for the plain two-flop synchronizer, plus reset.

## Interface
- `WIDTH`, 1: number of independent channels.
- `STAGES`, 2: synchronizer flops per channel; minimum 2. Smaller values are an elaboration error.
- `FILT_CYCLES`, 4: consecutive synchronized cycles a new level must persist before `o_q` follows; 0 bypasses the filter.
- `RST_VAL`, {WIDTH{1'b0}}: value loaded into every stage, `o_q` and edge history on reset.
- `i_clk` input 1: sole clock.
- `i_rst_n` input 1: asynchronous, active-low reset. Asserts asynchronously; release must be synchronous to `i_clk` upstream.
- `i_d` input WIDTH: asynchronous inputs, one per channel.
- `o_q` output WIDTH: synchronized, filtered levels.
- `o_rise` output WIDTH: one-cycle pulse on each 0→1 transition of `o_q[i]`.
- `o_fall` output WIDTH: one-cycle pulse on each 1→0 transition of `o_q[i]`.

## Operation
- Each channel has a `STAGES`-deep shift chain. `s[i]` is the last stage.
- All bits of a channel are independent. There is no cross-channel coherency. Multi-bit buses needing coherency must not use this block.
- Filter (`FILT_CYCLES>0`): per-channel counter `cnt`, width `$clog2(FILT_CYCLES+1)`.
  - If `s[i]==o_q[i]`: `cnt<=0`.
  - If `s[i]!=o_q[i]` and `cnt<FILT_CYCLES-1`: `cnt<=cnt+1`.
  - If `s[i]!=o_q[i]` and `cnt==FILT_CYCLES-1`: `o_q[i]<=s[i]`, `cnt<=0`.
  - Any single cycle of agreement restarts qualification from zero. A pulse shorter than `FILT_CYCLES` synchronized cycles never reaches `o_q`.
  - `cnt` never exceeds `FILT_CYCLES-1` and never wraps.
- Bypass (`FILT_CYCLES==0`): `o_q` is the last synchronizer stage directly. There is no counter and no extra register.
- Edge outputs: `q_d` holds `o_q` delayed one cycle.
  - `o_rise = o_q & ~q_d`.
  - `o_fall = ~o_q & q_d`.
  - Each pulse is exactly one cycle wide and coincides with the first cycle `o_q` shows the new value.
- Reset values:
  - all stages, `o_q` and `q_d` = `RST_VAL`; `cnt` = 0.
  - `o_rise` and `o_fall` are 0 during reset and on the first cycle after release.
- Reset mid-operation: any pending qualification is discarded. `o_q` jumps to `RST_VAL` asynchronously without generating pulses.

## Timing
- The input is sampled at edge 1 after it changes. Metastability may add one edge of uncertainty; all figures below assume a clean capture.
- Latency with filter: `o_q` changes after edge `STAGES+FILT_CYCLES`. Default: 6 edges.
- Latency in bypass: `o_q` changes after edge `STAGES`.
- Minimum input pulse guaranteed to propagate: `FILT_CYCLES+1` clock periods.
- Edge pulses add no latency beyond `o_q`.
- Simultaneous changes on several channels are processed independently within the same cycle.

## Configuration
- `SYNC_FF_FILT_EDGE_EN` defined:
  - `q_d` register and `o_rise`/`o_fall` logic are built as described.
- `SYNC_FF_FILT_EDGE_EN` undefined:
  - `q_d` is not instantiated.
  - `o_rise` and `o_fall` are tied to {WIDTH{1'b0}}.
  - Ports remain present, so instantiations are unchanged.
  - `o_q` behaviour is identical in both builds.

## Structure
- Package `sync_ff_pkg` holds:
  - `SYNC_FF_MIN_STAGES` = 2.
  - a counter-width helper function used by both modules.
- Sub-module `sync_ff_filt_ch` implements one channel: stage chain, counter, `o_q` and `q_d`. It is instantiated `WIDTH` times through a generate loop.
- The top level does only parameter checking and port fan-out.

## Test plan
1. Reset check. Hold `i_rst_n=0` and toggle `i_d` randomly. Required: `o_q`=`RST_VAL` and `o_rise`/`o_fall`=0 throughout. Then release reset with `i_d`=`RST_VAL`; no pulses may follow.
2. Clean rising edge, default parameters (`WIDTH=4`). Hold `i_d[0]` at 0→1. Required: `o_q[0]`=1 after exactly edge 6, `o_rise[0]` high for that one cycle only, other channels unaffected.
3. Short glitch, default parameters. Drive `i_d[1]` high for 3 cycles, then low. Required: `o_q[1]` stays 0, no pulses, `cnt` returns to 0.
4. Interrupted qualification. Drive `i_d[2]` high 3 cycles, low 1 cycle, then high. Required: `o_q[2]` rises only at edge 6 counted from the final rise.
5. Bypass mode (`FILT_CYCLES=0`, `STAGES=3`). Step `i_d[0]`. Required: `o_q[0]` follows after exactly 3 edges, and a 1-cycle input pulse appears as a 1-cycle `o_q` pulse.
6. Reset mid-count (`RST_VAL=4'b1010`). Assert `i_rst_n` low while `i_d[3]` is qualifying. Required: `o_q` becomes 4'b1010 asynchronously and no `o_rise`/`o_fall` pulse appears. Additionally, run tests 2 and 3 in a build without `SYNC_FF_FILT_EDGE_EN`; `o_rise`/`o_fall` must stay 0.
